i2c_slave_fifo: RTL and testbench

Synthesizable, clocked I2C slave that oversamples SDA/SCL with the system clock and replaces the event-driven behavioural test slave. It matches a programmable 7-bit address and streams received bytes into an RX FIFO. Bytes to send come from a TX FIFO, with ACK/NACK generation and overflow/underflow reporting. It sits between the FPGA pins (open-drain SDA, input-only SCL) and the user logic, for example the clock/display controller.

---
 rtl/i2c_slave_fifo.sv | 346 ++++++++++++++++++++++++++++++++++
 tb/tb_i2c_slave_fifo.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_fifo.sv
// i2c_slave_fifo -- clocked I2C slave with RX/TX byte FIFOs.
//
// SDA/SCL are oversampled with the system clock (which must run at least 16x
// SCL). The slave answers a programmable 7-bit address. Bytes the master
// writes are pushed into the RX FIFO. Bytes the master reads are popped from
// the TX FIFO, and 0xFF is sent when the TX FIFO is empty.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   sdaIn, sclIn        pin levels (asynchronous to clock)
//   sdaOe               1 = pull SDA low, 0 = release the pad
//   rxData/rxValid      RX FIFO head (first-word fall-through) / not empty
//   rxRead              pop the RX head
//   txData/txWrite      byte to queue for master reads / push strobe
//   txFull              TX FIFO full
//   startReceived, restartReceived, stopReceived   1-cycle bus event pulses
//   addressedForReceive/addressedForSend           address-match levels
//   rxOverflow          pulse: received byte NACKed because the RX FIFO is full
//   txUnderflow         pulse: 0xFF sent because the TX FIFO is empty
//
// Handshakes: a byte leaves the RX FIFO on every clock where rxValid and
// rxRead are both 1 (rxRead with rxValid=0 does nothing), and a byte enters
// the TX FIFO on every clock where txWrite=1 and txFull=0 (txWrite with
// txFull=1 does nothing).

module i2c_slave_fifo_queue #(
  parameter int Depth = 16,
  parameter int Width = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [Width-1:0] writeData,
  input  logic             push,
  input  logic             pop,
  output logic [Width-1:0] readData,
  output logic             empty,
  output logic             full
);
  localparam int PtrW = $clog2(Depth);
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
  localparam logic [PtrW:0] CntOne = (PtrW + 1)'(1);
  localparam logic [PtrW:0] CntFull = (PtrW + 1)'(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0] wrPtr;
  logic [PtrW-1:0] rdPtr;
  logic [PtrW:0] count;
  logic doPush;
  logic doPop;

  assign empty = (count == '0);
  assign full = (count == CntFull);
  assign doPush = push && !full;
  assign doPop = pop && !empty;
  assign readData = mem[rdPtr];

  // Depth is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PtrOne;
      if (doPop) rdPtr <= rdPtr + PtrOne;
      case ({doPush, doPop})
        2'b10: count <= count + CntOne;
        2'b01: count <= count - CntOne;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr] <= writeData;
  end
endmodule

module i2c_slave_fifo #(
  parameter logic [6:0] Address = 7'h50,
  parameter int RxDepth = 16,
  parameter int TxDepth = 16,
  parameter int SyncStages = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sdaIn,
  input  logic       sclIn,
  output logic       sdaOe,
  output logic [7:0] rxData,
  output logic       rxValid,
  input  logic       rxRead,
  input  logic [7:0] txData,
  input  logic       txWrite,
  output logic       txFull,
  output logic       startReceived,
  output logic       restartReceived,
  output logic       stopReceived,
  output logic       addressedForReceive,
  output logic       addressedForSend,
  output logic       rxOverflow,
  output logic       txUnderflow
);
  typedef enum logic [2:0] {
    Idle, Addr, AddrAck, RxByte, RxAck, TxByte, TxAck, Ignore
  } stateType;

  stateType state;
  stateType nextState;

  // Input synchronizers plus one edge-detect register. They reset to 1 (idle
  // bus) so leaving reset never looks like a START.
  logic [SyncStages-1:0] sdaSync;
  logic [SyncStages-1:0] sclSync;
  logic sdaS, sclS, sdaD, sclD;

  always_ff @(posedge clock) begin
    if (reset) begin
      sdaSync <= '1;
      sclSync <= '1;
      sdaD <= 1'b1;
      sclD <= 1'b1;
    end else begin
      sdaSync <= {sdaSync[SyncStages-2:0], sdaIn};
      sclSync <= {sclSync[SyncStages-2:0], sclIn};
      sdaD <= sdaS;
      sclD <= sclS;
    end
  end

  assign sdaS = sdaSync[SyncStages-1];
  assign sclS = sclSync[SyncStages-1];

  logic startEv, stopEv, sclRise, sclFall;
  assign startEv = sclS && sclD && sdaD && !sdaS;
  assign stopEv = sclS && sclD && !sdaD && sdaS;
  assign sclRise = sclS && !sclD;
  assign sclFall = !sclS && sclD;

  // FIFOs
  logic rxPush, rxFull, rxEmpty;
  logic txPop, txEmpty;
  logic [7:0] txHead;
  logic [7:0] rxByteNext;

  i2c_slave_fifo_queue #(.Depth(RxDepth), .Width(8)) rxFifo (
    .clock(clock), .reset(reset), .writeData(rxByteNext), .push(rxPush),
    .pop(rxRead), .readData(rxData), .empty(rxEmpty), .full(rxFull)
  );

  i2c_slave_fifo_queue #(.Depth(TxDepth), .Width(8)) txFifo (
    .clock(clock), .reset(reset), .writeData(txData), .push(txWrite),
    .pop(txPop), .readData(txHead), .empty(txEmpty), .full(txFull)
  );

  assign rxValid = !rxEmpty;

  // Datapath registers
  logic [7:0] shiftReg, shiftNext;
  logic [3:0] bitCnt, bitCntNext;
  logic ackSlot, ackSlotNext;   // 1 once the ACK slot has begun (first fall seen)
  logic ackOk, ackOkNext;       // RX slot answers ACK (1) or NACK (0)
  logic sdaOeNext, recvNext, sendNext;
  logic startNext, restartNext, stopNext, overflowNext, underflowNext;
  logic addrMatch;
  logic [7:0] txLoad;

  assign rxByteNext = {shiftReg[6:0], sdaS};
  assign addrMatch = (shiftReg[6:0] == Address);
  assign txLoad = txEmpty ? 8'hFF : txHead;

  // State register (and datapath registers)
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= Idle;
      shiftReg <= '0;
      bitCnt <= '0;
      ackSlot <= 1'b0;
      ackOk <= 1'b0;
      sdaOe <= 1'b0;
      addressedForReceive <= 1'b0;
      addressedForSend <= 1'b0;
      startReceived <= 1'b0;
      restartReceived <= 1'b0;
      stopReceived <= 1'b0;
      rxOverflow <= 1'b0;
      txUnderflow <= 1'b0;
    end else begin
      state <= nextState;
      shiftReg <= shiftNext;
      bitCnt <= bitCntNext;
      ackSlot <= ackSlotNext;
      ackOk <= ackOkNext;
      sdaOe <= sdaOeNext;
      addressedForReceive <= recvNext;
      addressedForSend <= sendNext;
      startReceived <= startNext;
      restartReceived <= restartNext;
      stopReceived <= stopNext;
      rxOverflow <= overflowNext;
      txUnderflow <= underflowNext;
    end
  end

  // Next-state logic. STOP beats START, which beats data events.
  always_comb begin
    nextState = state;
    if (stopEv) begin
      nextState = Idle;
    end else if (startEv) begin
      nextState = Addr;
    end else begin
      case (state)
        Addr:    if (sclRise && bitCnt == 4'd7) nextState = addrMatch ? AddrAck : Ignore;
        AddrAck: if (sclFall && ackSlot) nextState = addressedForSend ? TxByte : RxByte;
        RxByte:  if (sclRise && bitCnt == 4'd7) nextState = RxAck;
        RxAck:   if (sclFall && ackSlot) nextState = RxByte;
        TxByte:  if (sclFall && bitCnt == 4'd8) nextState = TxAck;
        TxAck:   if (sclRise) nextState = sdaS ? Ignore : TxByte;
        default: ;
      endcase
    end
  end

  // Output / datapath logic
  always_comb begin
    shiftNext = shiftReg;
    bitCntNext = bitCnt;
    ackSlotNext = ackSlot;
    ackOkNext = ackOk;
    sdaOeNext = sdaOe;
    recvNext = addressedForReceive;
    sendNext = addressedForSend;
    startNext = 1'b0;
    restartNext = 1'b0;
    stopNext = 1'b0;
    overflowNext = 1'b0;
    underflowNext = 1'b0;
    rxPush = 1'b0;
    txPop = 1'b0;
    if (stopEv) begin
      stopNext = 1'b1;
      sdaOeNext = 1'b0;
      ackSlotNext = 1'b0;
      recvNext = 1'b0;
      sendNext = 1'b0;
    end else if (startEv) begin
      // Any partial byte is simply dropped: bitCnt restarts at 0.
      if (state == Idle) startNext = 1'b1;
      else restartNext = 1'b1;
      sdaOeNext = 1'b0;
      bitCntNext = '0;
      ackSlotNext = 1'b0;
      recvNext = 1'b0;
      sendNext = 1'b0;
    end else begin
      case (state)
        Addr: begin
          if (sclRise) begin
            shiftNext = rxByteNext;
            bitCntNext = bitCnt + 4'd1;
            if (bitCnt == 4'd7) begin
              bitCntNext = '0;
              ackSlotNext = 1'b0;
              if (addrMatch) begin
                recvNext = !sdaS;
                sendNext = sdaS;
              end
            end
          end
        end
        AddrAck: begin
          if (sclFall) begin
            if (!ackSlot) begin
              sdaOeNext = 1'b1;
              ackSlotNext = 1'b1;
            end else begin
              ackSlotNext = 1'b0;
              if (addressedForSend) begin
                // The fall ending the ACK slot is also where the MSB goes out.
                txPop = !txEmpty;
                underflowNext = txEmpty;
                shiftNext = txLoad;
                sdaOeNext = !txLoad[7];
                bitCntNext = 4'd1;
              end else begin
                sdaOeNext = 1'b0;
                bitCntNext = '0;
              end
            end
          end
        end
        RxByte: begin
          if (sclRise) begin
            shiftNext = rxByteNext;
            bitCntNext = bitCnt + 4'd1;
            if (bitCnt == 4'd7) begin
              bitCntNext = '0;
              ackSlotNext = 1'b0;
              // Full is judged before any same-cycle rxRead frees a slot.
              if (rxFull) begin
                overflowNext = 1'b1;
                ackOkNext = 1'b0;
              end else begin
                rxPush = 1'b1;
                ackOkNext = 1'b1;
              end
            end
          end
        end
        RxAck: begin
          if (sclFall) begin
            if (!ackSlot) begin
              sdaOeNext = ackOk;
              ackSlotNext = 1'b1;
            end else begin
              sdaOeNext = 1'b0;
              ackSlotNext = 1'b0;
            end
          end
        end
        TxByte: begin
          if (sclFall) begin
            if (bitCnt == 4'd8) begin
              sdaOeNext = 1'b0;
              bitCntNext = '0;
            end else begin
              sdaOeNext = !shiftReg[3'd7 - bitCnt[2:0]];
              bitCntNext = bitCnt + 4'd1;
            end
          end
        end
        TxAck: begin
          if (sclRise && !sdaS) begin
            // Master ACK: load the next byte; its MSB goes out on the next fall.
            txPop = !txEmpty;
            underflowNext = txEmpty;
            shiftNext = txLoad;
            bitCntNext = '0;
          end
        end
        default: sdaOeNext = 1'b0;  // Idle, Ignore
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_slave_fifo.sv
// Bench for i2c_slave_fifo. Two slaves share one open-drain bus: dut1 with
// default parameters (address 0x50) and dut2 at address 0x2A with 2-entry
// FIFOs for the overflow and TX-full cases.
`timescale 1ns/1ps
module tb_i2c_slave_fifo;
  localparam int Q = 5;  // quarter SCL period in system clocks (SCL = clock/20)

  logic clock = 1'b0;
  logic reset;
  logic masterSda, masterScl;
  logic sdaIn;
  logic sdaOe1, sdaOe2;
  logic [7:0] rxData1, rxData2, txData1, txData2;
  logic rxValid1, rxValid2, rxRead1, rxRead2, txWrite1, txWrite2, txFull1, txFull2;
  logic start1, restart1, stop1, recv1, send1, overflow1, underflow1;
  logic start2, restart2, stop2, recv2, send2, overflow2, underflow2;

  int checks = 0;
  int errors = 0;
  int startCnt1 = 0, restartCnt1 = 0, stopCnt1 = 0, underflowCnt1 = 0, overflowCnt2 = 0;

  assign sdaIn = masterSda & ~sdaOe1 & ~sdaOe2;

  always #5 clock = ~clock;

  i2c_slave_fifo dut1 (
    .clock(clock), .reset(reset), .sdaIn(sdaIn), .sclIn(masterScl), .sdaOe(sdaOe1),
    .rxData(rxData1), .rxValid(rxValid1), .rxRead(rxRead1), .txData(txData1),
    .txWrite(txWrite1), .txFull(txFull1), .startReceived(start1),
    .restartReceived(restart1), .stopReceived(stop1), .addressedForReceive(recv1),
    .addressedForSend(send1), .rxOverflow(overflow1), .txUnderflow(underflow1)
  );

  i2c_slave_fifo #(.Address(7'h2A), .RxDepth(2), .TxDepth(2)) dut2 (
    .clock(clock), .reset(reset), .sdaIn(sdaIn), .sclIn(masterScl), .sdaOe(sdaOe2),
    .rxData(rxData2), .rxValid(rxValid2), .rxRead(rxRead2), .txData(txData2),
    .txWrite(txWrite2), .txFull(txFull2), .startReceived(start2),
    .restartReceived(restart2), .stopReceived(stop2), .addressedForReceive(recv2),
    .addressedForSend(send2), .rxOverflow(overflow2), .txUnderflow(underflow2)
  );

  // Pulse cycle counters: a pulse held for 2 cycles counts twice.
  always @(posedge clock) begin
    if (start1) startCnt1++;
    if (restart1) restartCnt1++;
    if (stop1) stopCnt1++;
    if (underflow1) underflowCnt1++;
    if (overflow2) overflowCnt2++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time expired, expected completion before 500000 ns");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic waitClk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic i2cStart();
    masterSda = 1'b0;
    waitClk(2 * Q);
    masterScl = 1'b0;
  endtask

  task automatic i2cRepStart();
    waitClk(Q); masterSda = 1'b1;
    waitClk(Q); masterScl = 1'b1;
    waitClk(Q); masterSda = 1'b0;
    waitClk(Q); masterScl = 1'b0;
  endtask

  task automatic i2cStop();
    waitClk(Q); masterSda = 1'b0;
    waitClk(Q); masterScl = 1'b1;
    waitClk(Q); masterSda = 1'b1;
    waitClk(2 * Q);
  endtask

  task automatic i2cBit(input logic b, output logic s);
    waitClk(Q); masterSda = b;
    waitClk(Q); masterScl = 1'b1;
    waitClk(Q); s = sdaIn;
    waitClk(Q); masterScl = 1'b0;
  endtask

  task automatic writeByte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) i2cBit(d[i], s);
    i2cBit(1'b1, ack);
  endtask

  task automatic readByte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      i2cBit(1'b1, s);
      d[i] = s;
    end
    i2cBit(nack, s);
  endtask

  task automatic popRx1();
    rxRead1 = 1'b1; waitClk(1); rxRead1 = 1'b0;
  endtask

  task automatic popRx2();
    rxRead2 = 1'b1; waitClk(1); rxRead2 = 1'b0;
  endtask

  task automatic pushTx1(input logic [7:0] d);
    txData1 = d; txWrite1 = 1'b1; waitClk(1); txWrite1 = 1'b0;
  endtask

  task automatic pushTx2(input logic [7:0] d);
    txData2 = d; txWrite2 = 1'b1; waitClk(1); txWrite2 = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; masterSda = 1'b1; masterScl = 1'b1;
    rxRead1 = 1'b0; rxRead2 = 1'b0; txWrite1 = 1'b0; txWrite2 = 1'b0;
    txData1 = 8'h00; txData2 = 8'h00;
    waitClk(5);
    checks++; if (sdaOe1 !== 1'b0) begin errors++; $display("FAIL reset_sdaOe: got %b expected 0", sdaOe1); end
    checks++; if (rxValid1 !== 1'b0) begin errors++; $display("FAIL reset_rxValid: got %b expected 0", rxValid1); end
    checks++; if (txFull1 !== 1'b0) begin errors++; $display("FAIL reset_txFull: got %b expected 0", txFull1); end
    checks++;
    if ({start1, restart1, stop1, recv1, send1, overflow1, underflow1} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000000",
               {start1, restart1, stop1, recv1, send1, overflow1, underflow1});
    end
    reset = 1'b0;
    waitClk(5);
  endtask

  task automatic test_write();
    logic ack;
    int s0, p0, r0;
    s0 = startCnt1; p0 = stopCnt1; r0 = restartCnt1;
    i2cStart();
    writeByte(8'hA0, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL write_addr_ack: got %b expected 0", ack); end
    checks++; if (recv1 !== 1'b1) begin errors++; $display("FAIL write_addressed: got %b expected 1", recv1); end
    writeByte(8'hA5, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL write_data1_ack: got %b expected 0", ack); end
    writeByte(8'h3C, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL write_data2_ack: got %b expected 0", ack); end
    i2cStop();
    checks++; if (recv1 !== 1'b0) begin errors++; $display("FAIL write_addressed_after_stop: got %b expected 0", recv1); end
    checks++; if (startCnt1 - s0 != 1) begin errors++; $display("FAIL write_start_pulses: got %0d expected 1", startCnt1 - s0); end
    checks++; if (stopCnt1 - p0 != 1) begin errors++; $display("FAIL write_stop_pulses: got %0d expected 1", stopCnt1 - p0); end
    checks++; if (restartCnt1 - r0 != 0) begin errors++; $display("FAIL write_restart_pulses: got %0d expected 0", restartCnt1 - r0); end
    checks++; if (rxValid1 !== 1'b1) begin errors++; $display("FAIL write_rxValid: got %b expected 1", rxValid1); end
    checks++; if (rxData1 !== 8'hA5) begin errors++; $display("FAIL write_rx_byte1: got %h expected a5", rxData1); end
    popRx1();
    checks++; if (rxData1 !== 8'h3C) begin errors++; $display("FAIL write_rx_byte2: got %h expected 3c", rxData1); end
    popRx1();
    checks++; if (rxValid1 !== 1'b0) begin errors++; $display("FAIL write_rx_empty: got %b expected 0", rxValid1); end
  endtask

  task automatic test_wrong_addr();
    logic ack;
    i2cStart();
    writeByte(8'hA2, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL wrong_addr_nack: got %b expected 1", ack); end
    writeByte(8'h11, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL wrong_addr_ignore: got %b expected 1", ack); end
    checks++; if ({recv1, send1} !== 2'b00) begin errors++; $display("FAIL wrong_addr_addressed: got %b expected 00", {recv1, send1}); end
    i2cStop();
    checks++; if (rxValid1 !== 1'b0) begin errors++; $display("FAIL wrong_addr_no_push: got %b expected 0", rxValid1); end
  endtask

  task automatic test_read();
    logic ack;
    logic [7:0] d;
    int u0, hits;
    u0 = underflowCnt1;
    pushTx1(8'h12);
    pushTx1(8'h34);
    i2cStart();
    writeByte(8'hA1, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL read_addr_ack: got %b expected 0", ack); end
    checks++; if ({send1, recv1} !== 2'b10) begin errors++; $display("FAIL read_addressed: got %b expected 10", {send1, recv1}); end
    readByte(1'b0, d);
    checks++; if (d !== 8'h12) begin errors++; $display("FAIL read_byte1: got %h expected 12", d); end
    readByte(1'b0, d);
    checks++; if (d !== 8'h34) begin errors++; $display("FAIL read_byte2: got %h expected 34", d); end
    readByte(1'b1, d);
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL read_byte3_empty: got %h expected ff", d); end
    checks++; if (underflowCnt1 - u0 != 1) begin errors++; $display("FAIL read_underflow_pulses: got %0d expected 1", underflowCnt1 - u0); end
    hits = 0;
    for (int i = 0; i < 6 * Q; i++) begin
      @(negedge clock);
      if (sdaOe1) hits++;
      if (i == 2 * Q) masterScl = 1'b1;   // extra clock pulses while ignored
      if (i == 4 * Q) masterScl = 1'b0;
    end
    checks++; if (hits != 0) begin errors++; $display("FAIL read_release_after_nack: got %0d driven cycles expected 0", hits); end
    i2cStop();
  endtask

  task automatic test_tx_full();
    logic ack;
    logic [7:0] d;
    pushTx2(8'h01);
    pushTx2(8'h02);
    pushTx2(8'h03);
    checks++; if (txFull2 !== 1'b1) begin errors++; $display("FAIL tx_full_flag: got %b expected 1", txFull2); end
    i2cStart();
    writeByte(8'h55, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL tx_full_addr_ack: got %b expected 0", ack); end
    readByte(1'b0, d);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL tx_full_byte1: got %h expected 01", d); end
    readByte(1'b0, d);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL tx_full_byte2: got %h expected 02", d); end
    readByte(1'b1, d);
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL tx_full_byte3: got %h expected ff", d); end
    i2cStop();
  endtask

  task automatic test_overflow();
    logic ack;
    int o0;
    o0 = overflowCnt2;
    i2cStart();
    writeByte(8'h54, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL overflow_addr_ack: got %b expected 0", ack); end
    writeByte(8'h11, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL overflow_byte1_ack: got %b expected 0", ack); end
    writeByte(8'h22, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL overflow_byte2_ack: got %b expected 0", ack); end
    writeByte(8'h33, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL overflow_byte3_nack: got %b expected 1", ack); end
    i2cStop();
    checks++; if (overflowCnt2 - o0 != 1) begin errors++; $display("FAIL overflow_pulses: got %0d expected 1", overflowCnt2 - o0); end
    checks++; if (rxData2 !== 8'h11) begin errors++; $display("FAIL overflow_head1: got %h expected 11", rxData2); end
    popRx2();
    checks++; if (rxData2 !== 8'h22) begin errors++; $display("FAIL overflow_head2: got %h expected 22", rxData2); end
    popRx2();
    checks++; if (rxValid2 !== 1'b0) begin errors++; $display("FAIL overflow_empty: got %b expected 0", rxValid2); end
  endtask

  task automatic test_restart();
    logic ack, s;
    logic [7:0] d;
    logic [3:0] partial;
    int s0, r0;
    s0 = startCnt1; r0 = restartCnt1;
    partial = 4'b1010;
    i2cStart();
    writeByte(8'hA0, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL restart_write_ack: got %b expected 0", ack); end
    for (int i = 3; i >= 0; i--) i2cBit(partial[i], s);
    i2cRepStart();
    writeByte(8'hA1, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL restart_read_ack: got %b expected 0", ack); end
    checks++; if (restartCnt1 - r0 != 1) begin errors++; $display("FAIL restart_pulses: got %0d expected 1", restartCnt1 - r0); end
    checks++; if (startCnt1 - s0 != 1) begin errors++; $display("FAIL restart_start_pulses: got %0d expected 1", startCnt1 - s0); end
    checks++; if ({send1, recv1} !== 2'b10) begin errors++; $display("FAIL restart_addressed: got %b expected 10", {send1, recv1}); end
    checks++; if (rxValid1 !== 1'b0) begin errors++; $display("FAIL restart_no_partial_push: got %b expected 0", rxValid1); end
    readByte(1'b1, d);
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL restart_read_empty: got %h expected ff", d); end
    i2cStop();
    checks++; if (send1 !== 1'b0) begin errors++; $display("FAIL restart_addressed_after_stop: got %b expected 0", send1); end
  endtask

  task automatic test_reset_mid_ack();
    logic ack, s;
    logic [7:0] a;
    a = 8'hA0;
    i2cStart();
    for (int i = 7; i >= 0; i--) i2cBit(a[i], s);
    waitClk(Q); masterSda = 1'b1;
    waitClk(Q); masterScl = 1'b1;
    waitClk(Q);
    checks++; if (sdaOe1 !== 1'b1) begin errors++; $display("FAIL reset_mid_ack_driven: got %b expected 1", sdaOe1); end
    reset = 1'b1;
    waitClk(1);
    checks++; if (sdaOe1 !== 1'b0) begin errors++; $display("FAIL reset_mid_ack_release: got %b expected 0", sdaOe1); end
    checks++; if ({rxValid1, txFull1} !== 2'b00) begin errors++; $display("FAIL reset_mid_ack_fifos: got %b expected 00", {rxValid1, txFull1}); end
    waitClk(3);
    reset = 1'b0;
    waitClk(10);
    i2cStart();
    writeByte(8'hA0, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL after_reset_addr_ack: got %b expected 0", ack); end
    writeByte(8'h5A, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL after_reset_data_ack: got %b expected 0", ack); end
    i2cStop();
    checks++; if (rxData1 !== 8'h5A || rxValid1 !== 1'b1) begin errors++; $display("FAIL after_reset_rx: got %h valid %b expected 5a valid 1", rxData1, rxValid1); end
    popRx1();
  endtask

  initial begin
    test_reset();
    test_write();
    test_wrong_addr();
    test_read();
    test_tx_full();
    test_overflow();
    test_restart();
    test_reset_mid_ack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
